// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout fault
module multicycle_control_unit #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          opcode,
  input  logic                instr_valid,
  input  logic                alu_zero,
  input  logic                alu_carry,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_write,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic                reg_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                zf,
  output logic                cf,
  output logic                busy,
  output logic                fault
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_ANDI = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_JUMP = 4'b0111;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_JE   = 4'b1011;
  localparam logic [3:0] OP_JA   = 4'b1100;
  localparam logic [3:0] OP_JB   = 4'b1101;
  localparam logic [3:0] OP_JAE  = 4'b1110;
  localparam logic [3:0] OP_JBE  = 4'b1111;

  // The wait that would bring the counter up to MEM_TIMEOUT is the last one tolerated.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] ir;
  logic [7:0] wait_cnt;
  logic [2:0] alu_code;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_AND) ||
           (op == OP_ANDI) || (op == OP_NAND) || (op == OP_NOR);
  endfunction

  function automatic logic [2:0] alu_code_of(input logic [3:0] op);
    logic [2:0] code;
    code = 3'b000;
    case (op)
      OP_AND:  code = 3'b001;
      OP_NAND: code = 3'b010;
      OP_NOR:  code = 3'b011;
      OP_ADDI: code = 3'b101;
      OP_ANDI: code = 3'b110;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  function automatic logic jump_taken(input logic [3:0] op, input logic z, input logic c);
    logic t;
    t = 1'b0;
    case (op)
      OP_JUMP: t = 1'b1;
      OP_JE:   t = z;
      OP_JA:   t = !z && !c;
      OP_JB:   t = !z && c;
      OP_JAE:  t = !c;
      OP_JBE:  t = z || c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Instruction register, compare flags and the MEM wait counter (held at zero outside MEM).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir       <= 4'b0000;
      zf       <= 1'b0;
      cf       <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      if (state == S_FETCH && instr_valid) begin
        ir <= opcode;
      end
      if (state == S_EXEC && ir == OP_CMP) begin
        zf <= alu_zero;
        cf <= alu_carry;
      end
      if (state != S_MEM) begin
        wait_cnt <= 8'd0;
      end else if (!mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Next-state decode; mem_ready wins over the timeout in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (instr_valid) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        if (is_alu(ir))                    next_state = S_WB;
        else if (ir == OP_LD || ir == OP_ST) next_state = S_MEM;
        else                               next_state = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)                     next_state = (ir == OP_LD) ? S_WB : S_FETCH;
        else if (wait_cnt == WAIT_LIMIT)   next_state = S_FAULT;
      end
      S_WB:     next_state = S_FETCH;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_FETCH;
    endcase
  end

  // Output decode from state, IR and flags; only the fetch handshake looks at instr_valid.
  always_comb begin
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_code   = 3'b000;
    case (state)
      S_FETCH: begin
        ir_load = instr_valid && reset;
        pc_inc  = instr_valid && reset;
      end
      S_EXEC: begin
        if (is_alu(ir)) begin
          alu_code = alu_code_of(ir);
          alu_src  = (ir == OP_ADDI) || (ir == OP_ANDI);
        end else if (ir == OP_CMP) begin
          alu_code = 3'b100;
        end else if (jump_taken(ir, zf, cf)) begin
          pc_write = 1'b1;
          branch   = 1'b1;
        end
      end
      S_MEM: begin
        mem_read  = (ir == OP_LD);
        mem_write = (ir == OP_ST);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (ir == OP_LD);
        if (is_alu(ir)) begin
          alu_code = alu_code_of(ir);
          alu_src  = (ir == OP_ADDI) || (ir == OP_ANDI);
        end
      end
      default: begin
      end
    endcase
  end

  assign alu_op = ALU_OP_W'(alu_code);
  assign busy   = (state != S_FETCH);
  assign fault  = (state == S_FAULT);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit against an instruction-level model
module tb_multicycle_control_unit;

  localparam int T = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   opcode;
  logic         instr_valid, alu_zero, alu_carry, mem_ready;
  logic         ir_load, pc_inc, pc_write, branch, mem_read, mem_write;
  logic         mem_to_reg, alu_src, reg_write, zf, cf, busy, fault;
  logic [W-1:0] alu_op;

  multicycle_control_unit #(.ALU_OP_W(W), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_write(pc_write), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .zf(zf), .cf(cf), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int lat;
    int flt;
    int rw;
    int m2r;
    int rd;
    int wr;
    int pcw;
    int br;
    int exec_alu;
    int wb_alu;
    int wb_src;
    int zf;
    int cf;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mzf = 0;
  int   mcf = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: cycle counts and control pulse totals per instruction.
  function automatic txn_t model(input int op, input int w, input int az, input int ac);
    txn_t e;
    int   taken;
    e = '{op: op, lat: 3, flt: 0, rw: 0, m2r: 0, rd: 0, wr: 0, pcw: 0, br: 0,
          exec_alu: 0, wb_alu: 0, wb_src: 0, zf: mzf, cf: mcf};
    case (op)
      1, 2, 3, 4, 5, 6: begin
        int codes[7] = '{0, 0, 5, 1, 6, 2, 3};
        e.lat = 4; e.rw = 1;
        e.exec_alu = codes[op]; e.wb_alu = codes[op];
        e.wb_src = (op == 2 || op == 4) ? 1 : 0;
      end
      7: begin e.pcw = 1; e.br = 1; end
      10: begin
        e.exec_alu = 4; mzf = az; mcf = ac; e.zf = az; e.cf = ac;
      end
      11, 12, 13, 14, 15: begin
        case (op)
          11: taken = mzf;
          12: taken = (mzf == 0 && mcf == 0) ? 1 : 0;
          13: taken = (mzf == 0 && mcf == 1) ? 1 : 0;
          14: taken = (mcf == 0) ? 1 : 0;
          default: taken = (mzf == 1 || mcf == 1) ? 1 : 0;
        endcase
        e.pcw = taken; e.br = taken;
      end
      8, 9: begin
        int n_mem;
        if (w < T) begin
          n_mem = w + 1;
          e.lat = 3 + n_mem + ((op == 8) ? 1 : 0);
          if (op == 8) begin e.rw = 1; e.m2r = 1; end
        end else begin
          n_mem = T; e.lat = 3 + T; e.flt = 1;
        end
        if (op == 8) e.rd = n_mem; else e.wr = n_mem;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Issue one instruction and drive its cycles; stop>0 truncates the run after that many cycles.
  task automatic run_instr(input int op, input int w, input int az, input int ac,
                           input int stop, output int flt);
    txn_t e;
    int   n;
    e = model(op, w, az, ac);
    exp_q.push_back(e);
    flt = e.flt;
    n = (stop > 0) ? stop : e.lat;
    for (int cyc = 0; cyc < n; cyc++) begin
      if (cyc == 0) begin
        instr_valid = 1'b1; opcode = 4'(op);
      end else begin
        instr_valid = 1'($urandom); opcode = 4'($urandom);
      end
      alu_zero  = (cyc == 2) ? 1'(az) : 1'($urandom);
      alu_carry = (cyc == 2) ? 1'(ac) : 1'($urandom);
      if ((op == 8 || op == 9) && cyc >= 3) mem_ready = ((cyc - 3) >= w);
      else mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic reset_now();
    #2 reset = 1'b0;
    #1;
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    check("rst_zf", zf, 0);
    check("rst_cf", cf, 0);
    instr_valid = 1'b0;
    @(posedge clk); #3 reset = 1'b1;
    mzf = 0; mcf = 0;
    @(posedge clk); #1;
  endtask

  task automatic hold_fault_then_reset();
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; opcode = 4'($urandom); mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    check("fault_sticky", fault, 1);
    reset_now();
  endtask

  // Monitor: follows each accepted instruction until FETCH or FAULT and scores it.
  initial begin
    txn_t o, e;
    int   k = 0;
    bit   in_txn = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_txn = 0;
        continue;
      end
      if (in_txn) begin
        k++;
        if (k == 2) o.exec_alu = int'(alu_op);
        o.rw  += int'(reg_write);
        o.m2r += int'(mem_to_reg);
        o.rd  += int'(mem_read);
        o.wr  += int'(mem_write);
        o.pcw += int'(pc_write);
        o.br  += int'(branch);
        if (reg_write) begin o.wb_alu = int'(alu_op); o.wb_src = int'(alu_src); end
        if (fault || !busy) begin
          o.lat = k; o.flt = int'(fault); o.zf = int'(zf); o.cf = int'(cf);
          check($sformatf("op%0d_latency", e.op), o.lat, e.lat);
          check($sformatf("op%0d_fault", e.op), o.flt, e.flt);
          check($sformatf("op%0d_reg_write", e.op), o.rw, e.rw);
          check($sformatf("op%0d_mem_to_reg", e.op), o.m2r, e.m2r);
          check($sformatf("op%0d_mem_read", e.op), o.rd, e.rd);
          check($sformatf("op%0d_mem_write", e.op), o.wr, e.wr);
          check($sformatf("op%0d_pc_write", e.op), o.pcw, e.pcw);
          check($sformatf("op%0d_branch", e.op), o.br, e.br);
          check($sformatf("op%0d_exec_alu_op", e.op), o.exec_alu, e.exec_alu);
          check($sformatf("op%0d_wb_alu_op", e.op), o.wb_alu, e.wb_alu);
          check($sformatf("op%0d_wb_alu_src", e.op), o.wb_src, e.wb_src);
          check($sformatf("op%0d_zf", e.op), o.zf, e.zf);
          check($sformatf("op%0d_cf", e.op), o.cf, e.cf);
          in_txn = 0;
        end else if (k > 60) begin
          check("txn_cycle_budget", k, 60);
          in_txn = 0;
        end
      end else if (fault) begin
        check("fault_hold_busy", busy, 1);
        check("fault_hold_ctrl", int'({pc_write, mem_read, mem_write, reg_write}), 0);
      end
      if (!in_txn && ir_load) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ir_load", 1, 0);
        end else begin
          e = exp_q.pop_front();
          o = '{op: e.op, lat: 0, flt: 0, rw: 0, m2r: 0, rd: 0, wr: 0, pcw: 0, br: 0,
                exec_alu: 0, wb_alu: 0, wb_src: 0, zf: 0, cf: 0};
          k = 0;
          in_txn = 1;
          check("accept_pc_inc", pc_inc, 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int flt;
    int op, w;
    reset = 1'b0; instr_valid = 1'b1; opcode = 4'h1;
    alu_zero = 1'b1; alu_carry = 1'b1; mem_ready = 1'b1;
    #12;
    check("reset_ir_load", ir_load, 0);
    check("reset_pc_inc", pc_inc, 0);
    check("reset_busy", busy, 0);
    check("reset_fault", fault, 0);
    check("reset_flags", int'({zf, cf}), 0);
    check("reset_alu_op", int'(alu_op), 0);
    instr_valid = 1'b0;
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;

    run_instr(1, 0, 0, 0, 0, flt);
    run_instr(10, 0, 1, 0, 0, flt);
    run_instr(11, 0, 0, 0, 0, flt);
    run_instr(13, 0, 0, 0, 0, flt);
    run_instr(8, 3, 0, 0, 0, flt);
    run_instr(8, T - 1, 0, 0, 0, flt);
    run_instr(9, T, 0, 0, 0, flt);
    if (flt != 0) hold_fault_then_reset();
    else check("directed_st_timeout", flt, 1);

    run_instr(10, 0, 1, 1, 0, flt);
    run_instr(9, T, 0, 0, 5, flt);
    check("midmem_mem_write", mem_write, 1);
    reset_now();
    run_instr(2, 0, 0, 0, 0, flt);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      w = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, T - 1);
      run_instr(op, w, $urandom_range(0, 1), $urandom_range(0, 1), 0, flt);
      if (flt != 0) hold_fault_then_reset();
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 2; j++) begin
          instr_valid = 1'b0; opcode = 4'($urandom); mem_ready = 1'($urandom);
          @(posedge clk); #1;
        end
      end
    end

    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_at_end", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters SHALL be as follows; each line gives name, default and meaning.
  ALU_OP_W  3   width of alu_op; values >=3 SHALL zero-extend the 3-bit codes.
  MEM_TIMEOUT  15   max wait cycles in MEM before fault; legal range 1..255.
REQ-002 Ports SHALL be as follows; each line gives name, direction, width and meaning.
  clk  in  1  single clock; all state changes on its rising edge.
  reset  in  1  asynchronous, active-low reset (0 = reset).
  opcode  in  4  instruction opcode [17:14] from instruction bus.
  instr_valid  in  1  instruction bus holds a valid instruction.
  alu_zero  in  1  ALU zero result for the current operation.
  alu_carry  in  1  ALU carry/borrow for the current operation.
  mem_ready  in  1  data memory has completed the current access.
  ir_load  out  1  capture instruction register; pulse.
  pc_inc  out  1  advance PC by one; pulse.
  pc_write  out  1  load PC with jump target.
  branch  out  1  control transfer taken.
  mem_read, mem_write, mem_to_reg, alu_src, reg_write  out  1 each  datapath controls.
  alu_op  out  ALU_OP_W  ALU operation code.
  zf, cf  out  1 each  registered flag outputs.
  busy  out  1  high in every state except FETCH.
  fault  out  1  sticky memory-timeout error.

Function
REQ-003 Opcode encodings SHALL be: NOP 0000, ADD 0001, ADDI 0010, AND 0011, ANDI 0100, NAND 0101, NOR 0110, JUMP 0111, LD 1000, ST 1001, CMP 1010, JE 1011, JA 1100, JB 1101, JAE 1110, JBE 1111.
REQ-004 ALU codes SHALL be: ADD 000, AND 001, NAND 010, NOR 011, SUB 100, ADDI 101, ANDI 110; alu_op SHALL default to 000.
REQ-005 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and FAULT.
REQ-006 FETCH: when instr_valid=1, ir_load=1 and pc_inc=1 for that cycle, opcode is latched into an internal 4-bit IR, and next state = DECODE; otherwise the FSM stays in FETCH with all outputs 0.
REQ-007 DECODE SHALL last one cycle with all datapath controls 0 and then go to EXEC.
REQ-008 EXEC for ALU ops (ADD, AND, NAND, NOR, ADDI, ANDI): alu_op per REQ-004, alu_src=1 only for ADDI/ANDI, next state = WB.
REQ-009 EXEC for CMP: alu_op=100, and zf<=alu_zero, cf<=alu_carry at the clock edge leaving EXEC; next state = FETCH.
REQ-010 zf and cf SHALL change only per REQ-009 and on reset.
REQ-011 EXEC for JUMP: pc_write=1, branch=1; next state = FETCH.
REQ-012 EXEC for conditional jumps SHALL use the registered zf/cf: JE taken if zf; JA if !zf&&!cf; JB if !zf&&cf; JAE if !cf; JBE if zf||cf.
REQ-013 A taken conditional jump SHALL assert pc_write=1 and branch=1 for one cycle; an untaken one asserts neither; next state = FETCH in both cases.
REQ-014 EXEC for LD/ST SHALL assert no controls and go to MEM; EXEC for NOP SHALL go to FETCH.
REQ-015 MEM: mem_read=1 (LD) or mem_write=1 (ST) SHALL be held every cycle until mem_ready=1 is sampled.
REQ-016 On mem_ready=1 in MEM: LD goes to WB, ST goes to FETCH.
REQ-017 MEM SHALL keep an 8-bit wait counter, cleared on MEM entry and incremented on each cycle with mem_ready=0; when it reaches MEM_TIMEOUT with mem_ready=0, next state = FAULT.
REQ-018 mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT SHALL count as success, not fault.
REQ-019 WB SHALL assert reg_write=1 for exactly one cycle, with mem_to_reg=1 for LD, 0 otherwise, and alu_op/alu_src held as in EXEC; next state = FETCH.
REQ-020 FAULT: fault=1, busy=1, all other controls 0; the FSM SHALL leave FAULT only via reset.
REQ-021 instr_valid outside FETCH and mem_ready outside MEM SHALL be ignored.
REQ-022 All outputs SHALL decode from state, IR and flags only (Moore).
REQ-023 Latencies from the accept cycle SHALL be: ALU op 4 cycles; CMP/jump/NOP 3; ST 3+waits+1; LD 3+waits+2.

Reset
REQ-024 reset=0 SHALL immediately force state FETCH, IR=0000, zf=cf=0, wait counter=0, fault=0 and all outputs 0, including mid-MEM or mid-WB.
REQ-025 Operation SHALL resume on the first rising clk edge after reset returns to 1.

Verification
REQ-026 ADD (0001), instr_valid=1 -> ir_load at cycle 0, alu_op=000 in cycles 2-3, reg_write=1 only in cycle 3, back in FETCH at cycle 4.
REQ-027 CMP with alu_zero=1, alu_carry=0, then JE -> zf=1, cf=0; JE gives pc_write=branch=1. Then JB -> not taken, pc_write=0.
REQ-028 LD with mem_ready asserted after 3 wait cycles -> mem_read high 4 cycles in MEM, then WB with reg_write=mem_to_reg=1.
REQ-029 ST, MEM_TIMEOUT=4, mem_ready held 0 -> FAULT after 4 wait cycles, fault=1 held; instr_valid is then ignored until reset.
REQ-030 reset=0 asserted mid-MEM of ST -> mem_write drops without waiting for clk; zf/cf/fault clear; the next instruction executes normally.
